// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: built-in self-test initiator for a single-port RAM.
// Writes an address-derived pattern to every word, reads it back and compares,
// then reports pass/fail, a saturating mismatch count and the first failing word.
// Optional macro RAM_BIST_INV_PASS_EN adds a second write/read pass using the
// inverted pattern before the final drain.
module ram_bist_ctrl #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned DW     = 32,
   parameter int unsigned RD_LAT = 1,
   parameter logic [31:0] SEED   = 32'hA5A5_5A5A
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          ram_wr,
   output logic          ram_rd,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_data_in,
   input  logic [DW-1:0] ram_data_out,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [6:0]    err_cnt,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_data
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WRITE     = 3'd1;
   localparam logic [2:0] ST_READ      = 3'd2;
   localparam logic [2:0] ST_DRAIN     = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;
`ifdef RAM_BIST_INV_PASS_EN
   localparam logic [2:0] ST_WRITE_INV = 3'd5;
   localparam logic [2:0] ST_READ_INV  = 3'd6;
`endif

   localparam int unsigned LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [6:0]  ERR_MAX = 7'd127;

   // Pattern: seed XOR the 5-bit address replicated across the word.
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      logic [4:0]  a5;
      logic [31:0] rep;
      a5  = 5'(a);
      rep = {a5, a5, a5, a5, a5, a5, a5[1:0]};
      return DW'(SEED ^ rep);
   endfunction

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [LW-1:0] drain_q, drain_d;
   logic          addr_last, drain_last;
   logic          wr_phase, rd_phase;

   logic          vld_sr [RD_LAT];
   logic [AW-1:0] tag_sr [RD_LAT];
`ifdef RAM_BIST_INV_PASS_EN
   logic          inv_phase;
   logic          inv_sr [RD_LAT];
`endif

   logic [DW-1:0] exp_data;
   logic          mismatch;

   logic [6:0]    err_cnt_q, err_cnt_d;
   logic [AW-1:0] fail_addr_q, fail_addr_d;
   logic [DW-1:0] fail_data_q, fail_data_d;
   logic          pass_q, pass_d;

   assign addr_last  = (addr_q == AW'(DEPTH - 1));
   assign drain_last = (drain_q == LW'(RD_LAT - 1));

   // Sequencer next state: one address per cycle per pass, then drain, then done.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_WRITE;
               addr_d  = '0;
            end
         end
         ST_WRITE: begin
            if (addr_last) begin
               state_d = ST_READ;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_READ: begin
            if (addr_last) begin
`ifdef RAM_BIST_INV_PASS_EN
               // Reads still in flight finish during the inverted write pass.
               state_d = ST_WRITE_INV;
`else
               state_d = ST_DRAIN;
`endif
               addr_d  = '0;
               drain_d = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
`ifdef RAM_BIST_INV_PASS_EN
         ST_WRITE_INV: begin
            if (addr_last) begin
               state_d = ST_READ_INV;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_READ_INV: begin
            if (addr_last) begin
               state_d = ST_DRAIN;
               addr_d  = '0;
               drain_d = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
`endif
         ST_DRAIN: begin
            if (drain_last) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         drain_q <= drain_d;
      end
   end

   // RAM-side outputs decoded from the current state; idle values are zero.
   always_comb begin
`ifdef RAM_BIST_INV_PASS_EN
      inv_phase = (state_q == ST_WRITE_INV) || (state_q == ST_READ_INV);
      wr_phase  = (state_q == ST_WRITE) || (state_q == ST_WRITE_INV);
      rd_phase  = (state_q == ST_READ) || (state_q == ST_READ_INV);
      busy      = wr_phase || rd_phase || (state_q == ST_DRAIN);
      ram_data_in = wr_phase ? (pat(addr_q) ^ {DW{inv_phase}}) : '0;
`else
      wr_phase  = (state_q == ST_WRITE);
      rd_phase  = (state_q == ST_READ);
      busy      = wr_phase || rd_phase || (state_q == ST_DRAIN);
      ram_data_in = wr_phase ? pat(addr_q) : '0;
`endif
      ram_wr   = wr_phase;
      ram_rd   = rd_phase;
      ram_addr = (wr_phase || rd_phase) ? addr_q : '0;
      done     = (state_q == ST_DONE);
   end

   // Read tag pipeline: stage RD_LAT-1 lines up with the returning read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            vld_sr[i] <= 1'b0;
            tag_sr[i] <= '0;
`ifdef RAM_BIST_INV_PASS_EN
            inv_sr[i] <= 1'b0;
`endif
         end
      end else begin
         vld_sr[0] <= ram_rd;
         tag_sr[0] <= ram_addr;
`ifdef RAM_BIST_INV_PASS_EN
         inv_sr[0] <= inv_phase;
`endif
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            tag_sr[i] <= tag_sr[i-1];
`ifdef RAM_BIST_INV_PASS_EN
            inv_sr[i] <= inv_sr[i-1];
`endif
         end
      end
   end

   // Compare returning data against the pattern of its tagged address.
   always_comb begin
`ifdef RAM_BIST_INV_PASS_EN
      exp_data = pat(tag_sr[RD_LAT-1]) ^ {DW{inv_sr[RD_LAT-1]}};
`else
      exp_data = pat(tag_sr[RD_LAT-1]);
`endif
      mismatch = vld_sr[RD_LAT-1] && (ram_data_out != exp_data);
   end

   // Result bookkeeping: cleared on start, updated per mismatch, pass latched at end.
   always_comb begin
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      pass_d      = pass_q;
      if ((state_q == ST_IDLE) && start) begin
         err_cnt_d   = '0;
         fail_addr_d = '0;
         fail_data_d = '0;
         pass_d      = 1'b0;
      end else if (mismatch) begin
         if (err_cnt_q == '0) begin
            fail_addr_d = tag_sr[RD_LAT-1];
            fail_data_d = ram_data_out;
         end
         if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 7'd1;
         end
      end
      // The final compare lands in the last drain cycle, so include it here.
      if ((state_q == ST_DRAIN) && drain_last) begin
         pass_d = (err_cnt_d == '0);
      end
   end

   // Result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         pass_q      <= pass_d;
      end
   end

   assign err_cnt   = err_cnt_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign pass      = pass_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural RAM with injectable faults, a result
// model derived from the pattern rule, and directed plus random fault runs.
module tb_ram_bist_ctrl;

   localparam int unsigned DEPTH  = 32;
   localparam int unsigned AW     = 5;
   localparam int unsigned DW     = 32;
   localparam int unsigned RD_LAT = 1;
   localparam logic [31:0] SEED   = 32'hA5A5_5A5A;
`ifdef RAM_BIST_INV_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int BUSY_LEN = 2 * NPASS * DEPTH + RD_LAT;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          ram_wr, ram_rd;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;
   logic          busy, done, pass;
   logic [6:0]    err_cnt;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;

   int n_checks = 0;
   int n_errs   = 0;
   int viol_cnt = 0;
   int port_bad = 0;

   // Behavioural RAM with per-word read faults: ((stored | or) & and) ^ xor.
   logic [31:0] mem   [DEPTH];
   logic [31:0] or_m  [DEPTH];
   logic [31:0] and_m [DEPTH];
   logic [31:0] xor_m [DEPTH];

   // Expected results.
   int          exp_err;
   int          exp_fa;
   logic [31:0] exp_fd;
   logic        exp_pass;

   ram_bist_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .RD_LAT(RD_LAT),
      .SEED  (SEED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ram_wr      (ram_wr),
      .ram_rd      (ram_rd),
      .ram_addr    (ram_addr),
      .ram_data_in (ram_data_in),
      .ram_data_out(ram_data_out),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err_cnt     (err_cnt),
      .fail_addr   (fail_addr),
      .fail_data   (fail_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_wr) mem[ram_addr] <= ram_data_in;
      if (ram_rd) ram_data_out <= ((mem[ram_addr] | or_m[ram_addr]) & and_m[ram_addr])
                                  ^ xor_m[ram_addr];
   end

   // Pattern from its arithmetic definition: low 2 address bits, then six
   // copies of the 5-bit address stacked above them, XOR seed.
   function automatic logic [31:0] pat_m(input int unsigned a);
      int unsigned rep;
      rep = a & 3;
      for (int i = 0; i < 6; i++) rep = rep | ((a & 31) << (2 + 5 * i));
      return SEED ^ rep;
   endfunction

   // Port protocol monitor.
   always @(negedge clk) begin
      if (ram_wr && ram_rd) viol_cnt++;
      if (ram_wr) begin
`ifdef RAM_BIST_INV_PASS_EN
         if (ram_data_in !== pat_m(ram_addr) && ram_data_in !== ~pat_m(ram_addr)) port_bad++;
`else
         if (ram_data_in !== pat_m(ram_addr)) port_bad++;
`endif
      end else if (ram_data_in !== '0) begin
         port_bad++;
      end
      if (!ram_wr && !ram_rd && ram_addr !== '0) port_bad++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < DEPTH; i++) begin
         or_m[i]  = '0;
         and_m[i] = '1;
         xor_m[i] = '0;
      end
   endtask

   // Reference model: every word in each pass reads back its written value
   // through the fault function; mismatches in address/pass order.
   task automatic compute_expect();
      logic [31:0] w, r;
      exp_err = 0;
      exp_fa  = 0;
      exp_fd  = '0;
      for (int p = 0; p < NPASS; p++) begin
         for (int a = 0; a < DEPTH; a++) begin
            w = pat_m(a) ^ ((p == 1) ? 32'hFFFF_FFFF : 32'h0);
            r = ((w | or_m[a]) & and_m[a]) ^ xor_m[a];
            if (r != w) begin
               if (exp_err == 0) begin
                  exp_fa = a;
                  exp_fd = r;
               end
               exp_err++;
            end
         end
      end
      exp_pass = (exp_err == 0);
      if (exp_err > 127) exp_err = 127;
   endtask

   // Pulse start, optionally re-pulse during the test, and time busy/done.
   task automatic run_and_check(input string tag, input int repulse_at);
      int cyc, busy_n, done_at;
      logic pass_at_done;
      compute_expect();
      busy_n = 0;
      done_at = -1;
      cyc = 0;
      pass_at_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      while (done_at < 0 && cyc < BUSY_LEN + 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (cyc == repulse_at) start = 1'b1;
         if (cyc == repulse_at + 1) start = 1'b0;
         if (busy) busy_n++;
         if (done) begin
            done_at = cyc;
            pass_at_done = pass;
         end
      end
      chk($sformatf("%s_busy_len", tag), busy_n, BUSY_LEN);
      chk($sformatf("%s_done_cycle", tag), done_at, BUSY_LEN + 1);
      chk($sformatf("%s_pass", tag), pass_at_done, exp_pass);
      chk($sformatf("%s_err_cnt", tag), err_cnt, exp_err);
      chk($sformatf("%s_fail_addr", tag), fail_addr, exp_fa);
      chk($sformatf("%s_fail_data", tag), fail_data, exp_fd);
      @(negedge clk);
      chk($sformatf("%s_done_width", tag), {done, busy}, 2'b00);
      chk($sformatf("%s_pass_held", tag), pass, exp_pass);
   endtask

   initial begin
      int b, cyc, d1, d2;
      logic [31:0] p5;
      rst   = 1'b1;
      start = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);
      chk("rst_ctl", {ram_wr, ram_rd, busy, done, pass, ram_addr, err_cnt, fail_addr}, '0);
      chk("rst_wdata", ram_data_in, '0);
      chk("rst_fdata", fail_data, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Fault-free run.
      run_and_check("clean", 0);

      // Stuck-at-1 on the lowest bit of word 5 where the pattern holds a 0.
      clear_faults();
      p5 = pat_m(5);
      b = 0;
      while (b < 31 && p5[b]) b++;
      or_m[5] = 32'h1 << b;
      run_and_check("stuck1_w5", 0);
      chk("stuck1_w5_spec_data", fail_data, p5 | (32'h1 << b));

      // Words 3, 9, 20 corrupted, then a clean rerun clears the result.
      clear_faults();
      xor_m[3]  = 32'h0000_0100;
      xor_m[9]  = 32'h8000_0001;
      xor_m[20] = 32'h00F0_0000;
      run_and_check("multi", 0);
      chk("multi_spec_addr", fail_addr, 3);
      clear_faults();
      run_and_check("after_multi", 0);

      // start re-pulsed mid-test must be ignored.
      run_and_check("repulse", 10);

`ifdef RAM_BIST_INV_PASS_EN
      // Stuck-at-0 in word 7: fails in exactly one of the two read passes.
      clear_faults();
      and_m[7] = ~(32'h1 << 4);
      run_and_check("inv_stuck0_w7", 0);
      chk("inv_stuck0_w7_cnt", err_cnt, 1);
      clear_faults();
`endif

      // Reset while writing address 10.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(ram_wr && ram_addr == 5'd10) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("rst_mid_reached", cyc < 50, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ctl", {ram_wr, ram_rd, busy, done, pass, ram_addr, err_cnt, fail_addr}, '0);
      chk("rst_mid_wdata", ram_data_in, '0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_idle", {busy, ram_wr, ram_rd}, 3'b000);
      run_and_check("after_rst", 0);

      // Randomised fault sets.
      for (int it = 0; it < 8; it++) begin
         int n, a, kind;
         clear_faults();
         n = $urandom_range(0, 4);
         for (int j = 0; j < n; j++) begin
            a = $urandom_range(0, DEPTH - 1);
            kind = $urandom_range(0, 2);
            case (kind)
               0: or_m[a] = or_m[a] | (32'h1 << $urandom_range(0, 31));
               1: and_m[a] = and_m[a] & ~(32'h1 << $urandom_range(0, 31));
               default: xor_m[a] = xor_m[a] ^ ($urandom | 32'h1);
            endcase
         end
         run_and_check($sformatf("rand%0d", it), 0);
      end

      // start held high: tests restart back to back.
      clear_faults();
      @(negedge clk);
      start = 1'b1;
      d1 = -1;
      d2 = -1;
      cyc = 0;
      while (d2 < 0 && cyc < 3 * BUSY_LEN) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            if (d1 < 0) d1 = cyc;
            else d2 = cyc;
         end
      end
      start = 1'b0;
      chk("held_start_period", d2 - d1, BUSY_LEN + 2);
      cyc = 0;
      while ((busy || done) && cyc < 2 * BUSY_LEN) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);

      chk("wr_rd_exclusive", viol_cnt, 0);
      chk("port_values", port_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
